// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmit core among NUM_REQ byte requesters with
// round-robin arbitration. A granted byte and its baud select are latched
// and handed to the core with a one-cycle tx_start. Completion is tracked
// through the core's tx_busy flag. A timeout aborts a frame whose core never
// raises busy or never drops it again.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req        per-requester request level
//   req_data   requester i byte at [i*DATA_W +: DATA_W]
//   req_baud   requester i baud select at [i*2 +: 2]
//   ack        1-cycle pulse: byte/baud latched for that requester
//   done       1-cycle pulse: frame transmitted (tx_busy fell)
//   err        1-cycle pulse: frame aborted on timeout
//   tx_start   1-cycle start pulse to the UART core
//   tx_data    byte to the core, held from ack until the next grant
//   baud_sel   baud select to the core, held from ack until the next grant
//   tx_busy    core busy flag
//   owner      index of the current/last granted requester
//   active     high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter  int unsigned IDX_W       = 2,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned SETTLE_CYC  = 16,
  parameter  int unsigned TIMEOUT_CYC = 600000,
  parameter  int unsigned CNT_W       = 20,
  localparam int unsigned NUM_REQ     = 1 << IDX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_baud,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [1:0]                baud_sel,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          owner,
  output logic                      active
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    ptr_q,      ptr_d;
  logic [IDX_W-1:0]    owner_q,    owner_d;
  logic [DATA_W-1:0]   tx_data_q,  tx_data_d;
  logic [1:0]          baud_sel_q, baud_sel_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [NUM_REQ-1:0]  ack_q,      ack_d;
  logic [NUM_REQ-1:0]  done_q,     done_d;
  logic [NUM_REQ-1:0]  err_q,      err_d;
  logic                tx_start_q, tx_start_d;
  logic                active_q,   active_d;

  logic                grant_valid;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    cand;
  logic [DATA_W-1:0]   win_data;
  logic [1:0]          win_baud;
  logic                timed_out;

  // Round-robin pick: search upward from ptr+1, wrapping; ptr itself is last.
  always_comb begin
    grant_valid = 1'b0;
    winner      = ptr_q;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        winner      = cand;
      end
    end
  end

  // Payload of the selected requester.
  always_comb begin
    win_data = req_data[winner*DATA_W +: DATA_W];
    win_baud = req_baud[winner*2 +: 2];
  end

  // Counter runs from START through both wait states; this flags its last value.
  assign timed_out = (cnt_q == TIMEOUT_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    baud_sel_d = baud_sel_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    tx_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !tx_busy) begin
          ptr_d      = winner;
          owner_d    = winner;
          tx_data_d  = win_data;
          baud_sel_d = win_baud;
          ack_d      = NUM_REQ'(1) << winner;
          cnt_d      = '0;
          // baud_sel_q still holds the previous frame's baud here, so it
          // serves as the last-baud register for the settle decision.
          if (win_baud != baud_sel_q) begin
            state_d = ST_SETTLE;
          end else begin
            state_d    = ST_START;
            tx_start_d = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d    = ST_START;
          tx_start_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_START: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end

      // A busy rise on the timeout cycle wins over the abort.
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (timed_out) begin
          state_d = ST_IDLE;
          err_d   = NUM_REQ'(1) << owner_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A busy fall on the timeout cycle completes the frame instead.
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
          done_d  = NUM_REQ'(1) << owner_q;
        end else if (timed_out) begin
          state_d = ST_IDLE;
          err_d   = NUM_REQ'(1) << owner_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset overrides everything, even mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      tx_data_q  <= '0;
      baud_sel_q <= 2'b00;
      cnt_q      <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      baud_sel_q <= baud_sel_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign baud_sel = baud_sel_q;
  assign owner    = owner_q;
  assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Drives requesters and a behavioural UART core, predicts every output from
// a transaction-level model (grant timestamps and frame deadlines) and
// compares each cycle. Directed scenarios first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int IDX_W       = 2;
  localparam int NUM_REQ     = 1 << IDX_W;
  localparam int DATA_W      = 8;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 20;
  localparam int NEVER       = 32'h3fff_ffff;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*2-1:0]      req_baud;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic [1:0]                baud_sel;
  logic                      tx_busy;
  logic [IDX_W-1:0]          owner;
  logic                      active;

  uart_tx_arbiter #(
    .IDX_W      (IDX_W),
    .DATA_W     (DATA_W),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_data(req_data),
    .req_baud(req_baud),
    .ack     (ack),
    .done    (done),
    .err     (err),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .baud_sel(baud_sel),
    .tx_busy (tx_busy),
    .owner   (owner),
    .active  (active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Requester side of the bench.
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] hold;
  logic [7:0]         rq_data [NUM_REQ];
  logic [1:0]         rq_baud [NUM_REQ];
  bit                 rand_mode;

  // Behavioural core: busy is high for negedges in [rise_at, fall_at).
  int rise_at;
  int fall_at;
  int core_mode;
  bit busy_force;

  // Reference model state.
  bit                 m_idle;
  int                 m_ptr;
  int                 m_owner;
  logic [7:0]         m_data;
  logic [1:0]         m_baud;
  logic [1:0]         m_last;
  int                 m_start;
  bit                 m_rose;
  logic [NUM_REQ-1:0] e_ack;
  logic [NUM_REQ-1:0] e_done;
  logic [NUM_REQ-1:0] e_err;
  bit                 e_start;
  bit                 e_active;

  // Observations.
  int q_grant[$];
  int obs_done;
  int obs_err;
  int obs_start;
  int last_ack_cyc;
  int last_start_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (p + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Predict the outputs for the cycle after the coming edge (cycle cyc+1).
  task automatic model_edge();
    int n;
    int w;
    n      = cyc;
    e_ack  = '0;
    e_done = '0;
    e_err  = '0;
    if (reset) begin
      m_idle  = 1'b1;
      m_ptr   = 0;
      m_owner = 0;
      m_data  = '0;
      m_baud  = 2'b00;
      m_last  = 2'b00;
      m_rose  = 1'b0;
      m_start = 0;
    end else if (m_idle) begin
      if (|req && !tx_busy) begin
        w        = rr_pick(req, m_ptr);
        m_ptr    = w;
        m_owner  = w;
        m_data   = rq_data[w];
        m_baud   = rq_baud[w];
        e_ack[w] = 1'b1;
        m_start  = n + 1 + ((rq_baud[w] != m_last) ? SETTLE_CYC : 0);
        m_last   = rq_baud[w];
        m_rose   = 1'b0;
        m_idle   = 1'b0;
      end
    end else if (n > m_start) begin
      // Frame deadline: the edge after the cycle start+TIMEOUT_CYC aborts.
      if (m_rose) begin
        if (!tx_busy) begin
          e_done[m_owner] = 1'b1;
          m_idle          = 1'b1;
        end else if (n == m_start + TIMEOUT_CYC) begin
          e_err[m_owner] = 1'b1;
          m_idle         = 1'b1;
        end
      end else begin
        if (tx_busy) begin
          m_rose = 1'b1;
        end else if (n == m_start + TIMEOUT_CYC) begin
          e_err[m_owner] = 1'b1;
          m_idle         = 1'b1;
        end
      end
    end
    e_start  = !m_idle && (n + 1 == m_start);
    e_active = !m_idle;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]                     = pend[i];
      req_data[i*DATA_W +: DATA_W] = rq_data[i];
      req_baud[i*2 +: 2]         = rq_baud[i];
    end
    tx_busy = busy_force || (cyc >= rise_at && cyc < fall_at);
  endtask

  task automatic schedule_core();
    int mode;
    mode = core_mode;
    if (rand_mode) begin
      mode = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 5));
    end
    case (mode)
      0: begin
        rise_at = cyc + int'($urandom_range(0, 3));
        fall_at = rise_at + int'($urandom_range(1, 12));
      end
      1: begin rise_at = NEVER; fall_at = NEVER; end
      2: begin rise_at = cyc + 1; fall_at = NEVER; end
      3: begin rise_at = cyc + TIMEOUT_CYC; fall_at = rise_at + 5; end
      4: begin rise_at = cyc + 1; fall_at = cyc + TIMEOUT_CYC; end
      5: begin rise_at = cyc + 1; fall_at = cyc + TIMEOUT_CYC + 1; end
      default: begin rise_at = cyc + 1; fall_at = cyc + 11; end
    endcase
  endtask

  task automatic react();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (e_ack[i]) begin
        if (hold[i]) begin
          pend[i] = 1'b1;
        end else if (rand_mode) begin
          pend[i]    = ($urandom_range(0, 99) < 30);
          rq_data[i] = 8'($urandom);
          rq_baud[i] = 2'($urandom);
        end else begin
          pend[i] = 1'b0;
        end
      end else if (rand_mode) begin
        if (pend[i]) begin
          if ($urandom_range(0, 99) < 3) pend[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 15) begin
          pend[i]    = 1'b1;
          rq_data[i] = 8'($urandom);
          rq_baud[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : rq_baud[i];
        end
      end
    end
    if (reset) begin
      rise_at = 0;
      fall_at = 0;
    end else begin
      if (e_start) schedule_core();
      if (|e_err && fall_at > cyc + 2) fall_at = cyc + 2;
    end
    drive();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("ack",      32'(ack),      32'(e_ack));
    chk("done",     32'(done),     32'(e_done));
    chk("err",      32'(err),      32'(e_err));
    chk("tx_start", 32'(tx_start), 32'(e_start));
    chk("active",   32'(active),   32'(e_active));
    chk("owner",    32'(owner),    32'(m_owner));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    chk("baud_sel", 32'(baud_sel), 32'(m_baud));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) begin
        q_grant.push_back(i);
        last_ack_cyc = cyc;
      end
    end
    if (tx_start) begin
      obs_start++;
      last_start_cyc = cyc;
    end
    obs_done += $countones(done);
    obs_err  += $countones(err);
    react();
  endtask

  task automatic clear_obs();
    q_grant.delete();
    obs_done  = 0;
    obs_err   = 0;
    obs_start = 0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pend       = '0;
    hold       = '0;
    busy_force = 1'b0;
    rand_mode  = 1'b0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    drive();
    clear_obs();
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] b);
    pend[i]    = 1'b1;
    rq_data[i] = d;
    rq_baud[i] = b;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (!(m_idle && pend == '0 && !tx_busy) && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 32'(m_idle && pend == '0 && !tx_busy), 32'd1);
  endtask

  task automatic run_until_grants(input string tag, input int n, input int max_cyc);
    int k;
    k = 0;
    while (q_grant.size() < n && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 32'(q_grant.size() >= n), 32'd1);
  endtask

  int exp_arb [4]  = '{1, 2, 3, 0};
  int exp_fair[4]  = '{2, 0, 2, 0};
  int to_mode [5]  = '{1, 2, 3, 4, 5};
  int to_err  [5]  = '{1, 1, 0, 0, 1};
  int to_done [5]  = '{0, 0, 1, 1, 0};

  initial begin
    reset      = 1'b1;
    pend       = '0;
    hold       = '0;
    busy_force = 1'b0;
    rand_mode  = 1'b0;
    rise_at    = 0;
    fall_at    = 0;
    core_mode  = 0;
    m_idle     = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_data[i] = '0;
      rq_baud[i] = 2'b00;
    end
    drive();

    // Sequencing with a baud change: settle then a 10-cycle busy frame.
    do_reset();
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_owner",  32'(owner),  32'd0);
    core_mode = 6;
    set_req(2, 8'hAA, 2'b01);
    drive();
    drain("seq_drain", 200);
    chk("seq_grants", 32'(q_grant.size()), 32'd1);
    if (q_grant.size() >= 1) chk("seq_winner", 32'(q_grant[0]), 32'd2);
    chk("seq_settle", 32'(last_start_cyc - last_ack_cyc), 32'(SETTLE_CYC));
    chk("seq_done",   32'(obs_done), 32'd1);

    // Arbitration order with all four requesting at the same baud.
    do_reset();
    core_mode = 0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h10 + i), 2'b00);
    drive();
    drain("arb_drain", 400);
    chk("arb_grants", 32'(q_grant.size()), 32'd4);
    for (int k = 0; k < 4 && k < q_grant.size(); k++) chk("arb_order", 32'(q_grant[k]), 32'(exp_arb[k]));
    chk("arb_nosettle", 32'(last_start_cyc - last_ack_cyc), 32'd0);

    // Fairness between two persistent requesters, then a settle on baud change.
    do_reset();
    hold[0] = 1'b1;
    hold[2] = 1'b1;
    set_req(0, 8'h20, 2'b00);
    set_req(2, 8'h22, 2'b00);
    drive();
    run_until_grants("fair_wait", 4, 400);
    hold = '0;
    pend = '0;
    drive();
    drain("fair_drain", 200);
    for (int k = 0; k < 4 && k < q_grant.size(); k++) chk("fair_order", 32'(q_grant[k]), 32'(exp_fair[k]));
    clear_obs();
    set_req(2, 8'h5C, 2'b11);
    drive();
    drain("settle_drain", 200);
    chk("settle_len", 32'(last_start_cyc - last_ack_cyc), 32'(SETTLE_CYC));

    // Timeout variants, including busy edges landing on the deadline.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      core_mode = to_mode[t];
      clear_obs();
      set_req(1, 8'(8'hC0 + t), 2'b00);
      drive();
      drain("to_drain", 300);
      chk("to_err",   32'(obs_err),   32'(to_err[t]));
      chk("to_done",  32'(obs_done),  32'(to_done[t]));
      chk("to_start", 32'(obs_start), 32'd1);
    end

    // Busy gating in idle.
    do_reset();
    core_mode  = 0;
    busy_force = 1'b1;
    set_req(1, 8'h77, 2'b00);
    drive();
    for (int k = 0; k < 10; k++) tick();
    chk("gate_hold", 32'(q_grant.size()), 32'd0);
    busy_force = 1'b0;
    drive();
    tick();
    chk("gate_grant", 32'(q_grant.size()), 32'd1);
    drain("gate_drain", 200);

    // Reset in the middle of a frame.
    do_reset();
    core_mode = 2;
    set_req(3, 8'h3C, 2'b00);
    drive();
    begin
      int k;
      k = 0;
      while (!(!m_idle && m_rose) && k < 50) begin
        tick();
        k++;
      end
      chk("mid_reach", 32'(!m_idle && m_rose), 32'd1);
    end
    reset = 1'b1;
    drive();
    tick();
    chk("mid_active",   32'(active),   32'd0);
    chk("mid_owner",    32'(owner),    32'd0);
    chk("mid_tx_data",  32'(tx_data),  32'd0);
    reset     = 1'b0;
    core_mode = 0;
    clear_obs();
    set_req(0, 8'h01, 2'b00);
    set_req(1, 8'h02, 2'b00);
    drive();
    drain("mid_drain", 200);
    if (q_grant.size() >= 1) chk("mid_first", 32'(q_grant[0]), 32'd1);
    chk("mid_grants", 32'(q_grant.size()), 32'd2);

    // Randomized traffic with occasional resets.
    do_reset();
    rand_mode = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 399) == 0);
      drive();
      tick();
    end
    reset     = 1'b0;
    rand_mode = 1'b0;
    hold      = '0;
    pend      = '0;
    drive();
    drain("rand_drain", 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
